joust2_rom_loader: RTL and testbench
====================================

JOUST2_ROM_LOADER -- requirements
Module: joust2_rom_loader

Interface
REQ-001 Parameter ROM_INDEX, default 8'd0: the only ioctl_index value that is loaded.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer depth, power of two.
REQ-003 Parameter WAIT_LEVEL, default 2: fill level at or above which ioctl_wait is asserted.
REQ-004 Parameter EXPECTED_BYTES, default 131072: byte count required for a good load.
REQ-005 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 ioctl_download  in  1  download window from hps_io.
REQ-008 ioctl_index  in  8  download target index.
REQ-009 ioctl_wr  in  1  one-cycle byte strobe.
REQ-010 ioctl_addr  in  17  byte address.
REQ-011 ioctl_dout  in  8  byte data.
REQ-012 ioctl_wait  out  1  back-pressure to hps_io.
REQ-013 rom_we  out  1  write request (valid) to core ROM ports.
REQ-014 rom_ack  in  1  core accepts the write (ready).
REQ-015 rom_sel  out  2  region: 0 CPU, 1 sound, 2 graphics.
REQ-016 rom_addr  out  16  region-relative address.
REQ-017 rom_data  out  8  write data.
REQ-018 load_busy  out  1  high in LOAD and DRAIN.
REQ-019 load_done  out  1  high in DONE.
REQ-020 load_error  out  1  sticky error flag, valid in DONE.
REQ-021 checksum  out  16  sum of accepted bytes, modulo 2^16.

Function
REQ-022 A byte is accepted when ioctl_wr=1, ioctl_download=1, ioctl_index=ROM_INDEX, state is LOAD, and the FIFO is not full.
REQ-023 An accepted byte is pushed into the FIFO with its decoded region and address (ioctl_addr[16] is the MSB).
  - ioctl_addr[16]=0: rom_sel 0, rom_addr ioctl_addr[15:0].
  - ioctl_addr[16:15]=2'b10: rom_sel 1, rom_addr {1'b0, ioctl_addr[14:0]}.
  - ioctl_addr[16:15]=2'b11: rom_sel 2, rom_addr {1'b0, ioctl_addr[14:0]}.
REQ-024 The FIFO head drives rom_we, rom_sel, rom_addr and rom_data; rom_we=1 whenever the FIFO is non-empty.
REQ-025 Output fields hold stable while rom_we=1 and rom_ack=0.
REQ-026 A pop occurs on the cycle where rom_we=1 and rom_ack=1.
REQ-027 A push and a pop in the same cycle leave the fill count unchanged.
REQ-028 ioctl_wait is registered and equals 1 when fill count >= WAIT_LEVEL, else 0.
REQ-029 A strobe arriving while the FIFO is full is dropped and sets load_error.
REQ-030 State IDLE -> LOAD on the rising edge of ioctl_download with a matching index; this clears the byte counter, checksum and load_error.
REQ-031 State LOAD -> DRAIN when ioctl_download falls.
REQ-032 State DRAIN -> DONE on the cycle the FIFO becomes empty; a DRAIN entered with the FIFO already empty transitions the next cycle.
REQ-033 On entry to DONE, load_error is set if the byte count != EXPECTED_BYTES.
REQ-034 DONE -> LOAD on the next matching download rising edge; DONE is otherwise held.
REQ-035 Downloads with a non-matching index are ignored in every state and never change outputs.
REQ-036 Byte counter is 18 bits and saturates at 2^18-1.
REQ-037 Checksum adds each accepted byte, zero-extended, and wraps modulo 2^16.
REQ-038 Latency from accepted strobe to rom_we=1 is exactly 1 cycle when the FIFO is empty.

Reset
REQ-039 While reset_n=0 at a clock edge, state becomes IDLE and the FIFO is emptied.
REQ-040 Reset values: ioctl_wait=0, rom_we=0, rom_sel=0, rom_addr=0, rom_data=0, load_busy=0, load_done=0, load_error=0, checksum=0.
REQ-041 Reset asserted mid-LOAD discards buffered bytes; no rom_we is issued after the reset edge.

Structure
REQ-042 Region codes, the state enum and the EXPECTED_BYTES default belong in the shared package joust2_pkg.
REQ-043 The FIFO is one sub-module, loader_fifo, with width, depth, push, pop, full, empty and count.

Verification
REQ-044 Scenario: 131072 sequential bytes, data = addr[7:0], rom_ack tied 1.
  - Response: load_done=1, load_error=0, checksum=16'h0000, 65536 writes on sel 0 and 32768 each on sel 1 and sel 2.
REQ-045 Scenario: byte 8'hA5 at addr 17'h18004.
  - Response: next cycle rom_we=1, rom_sel=2, rom_addr=16'h0004, rom_data=8'hA5.
REQ-046 Scenario: rom_ack held 0, strobes every cycle.
  - Response: ioctl_wait=1 after the 2nd push.
  - A 5th strobe while full sets load_error.
  - rom_data stays equal to the first byte.
REQ-047 Scenario: download ends after 100 bytes.
  - Response: DRAIN, then DONE with load_error=1 and checksum equal to the sum of the 100 bytes.
REQ-048 Scenario: reset_n pulsed low mid-LOAD with 3 bytes buffered.
  - Response: rom_we=0 next cycle and state IDLE.
REQ-049 Scenario: download with ioctl_index=1.
  - Response: no rom_we and outputs unchanged.

Source files
------------

// File: rtl/joust2_pkg.sv
// Shared types for the Joust 2 ROM loader: FSM states, ROM regions and
// the decode from hps_io byte address to region-relative ROM write.
package joust2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

  typedef enum logic [1:0] {
    SEL_CPU   = 2'd0,
    SEL_SOUND = 2'd1,
    SEL_GFX   = 2'd2
  } rom_sel_e;

  localparam int unsigned EXPECTED_BYTES_DEFAULT = 131072;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } rom_wr_t;

  // Lower 64K is CPU ROM, then 32K sound, then 32K graphics.
  function automatic rom_wr_t decode_byte(input logic [16:0] a, input logic [7:0] d);
    rom_wr_t w;
    w.data = d;
    if (!a[16]) begin
      w.sel  = SEL_CPU;
      w.addr = a[15:0];
    end else if (!a[15]) begin
      w.sel  = SEL_SOUND;
      w.addr = {1'b0, a[14:0]};
    end else begin
      w.sel  = SEL_GFX;
      w.addr = {1'b0, a[14:0]};
    end
    return w;
  endfunction

endpackage

// File: rtl/joust2_rom_loader_fifo.sv
// Small synchronous FIFO buffering decoded ROM writes between hps_io and
// the core ROM ports. Head word reads as zero while empty.
module loader_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = count_q[AW];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers, count and storage contents.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/joust2_rom_loader.sv
// Joust 2 ROM loader: accepts hps_io download bytes for one index, decodes
// them into CPU/sound/graphics ROM writes, buffers them in a FIFO with
// valid/ready handshake, and reports progress, byte-count error and checksum.
module joust2_rom_loader
  import joust2_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX      = 8'd0,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned WAIT_LEVEL     = 2,
  parameter int unsigned EXPECTED_BYTES = EXPECTED_BYTES_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_we,
  input  logic        rom_ack,
  output logic [1:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] checksum
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  load_state_e state_q, state_d;
  logic        dl_q, dl_d;
  logic [17:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] checksum_q, checksum_d;
  logic        error_q, error_d;
  logic        wait_q, wait_d;

  logic          index_ok, strobe_hit, dl_rise, dl_fall;
  logic          accept, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fill_next;
  rom_wr_t       head;

  assign index_ok   = (ioctl_index == ROM_INDEX);
  assign strobe_hit = ioctl_wr && ioctl_download && index_ok;
  assign dl_rise    = ioctl_download && !dl_q && index_ok;
  assign dl_fall    = !ioctl_download && dl_q;
  assign accept     = strobe_hit && (state_q == ST_LOAD) && !fifo_full;
  assign rom_we     = !fifo_empty;
  assign pop        = rom_we && rom_ack;

  loader_fifo #(
    .WIDTH ($bits(rom_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (accept),
    .din   (decode_byte(ioctl_addr, ioctl_dout)),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rom_sel    = head.sel;
  assign rom_addr   = head.addr;
  assign rom_data   = head.data;
  assign ioctl_wait = wait_q;
  assign load_busy  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign load_done  = (state_q == ST_DONE);
  assign load_error = error_q;
  assign checksum   = checksum_q;

  // Next state, byte counter, checksum, error flag and back-pressure.
  always_comb begin
    state_d    = state_q;
    dl_d       = ioctl_download;
    byte_cnt_d = byte_cnt_q;
    checksum_d = checksum_q;
    error_d    = error_q;
    fill_next  = fifo_count;

    if (accept && !pop) begin
      fill_next = fifo_count + CW'(1);
    end else if (!accept && pop) begin
      fill_next = fifo_count - CW'(1);
    end
    // Registered from the post-edge fill level so it tracks the count exactly.
    wait_d = (fill_next >= CW'(WAIT_LEVEL));

    if (accept) begin
      byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 18'd1;
      checksum_d = checksum_q + {8'h00, ioctl_dout};
    end
    if (strobe_hit && (state_q == ST_LOAD) && fifo_full) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          byte_cnt_d = '0;
          checksum_d = '0;
          error_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (dl_fall) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty || ((fifo_count == CW'(1)) && pop)) begin
          state_d = ST_DONE;
          if (byte_cnt_q != 18'(EXPECTED_BYTES)) error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dl_q       <= 1'b0;
      byte_cnt_q <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      byte_cnt_q <= byte_cnt_d;
      checksum_q <= checksum_d;
      error_q    <= error_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_joust2_rom_loader.sv
// Directed bench for joust2_rom_loader: table of address-decode vectors plus
// hand-written sequences for back-pressure, short load, reset, foreign index
// and a complete (reduced-size) load checked against a write scoreboard.
module tb_joust2_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic        rom_ack;
  logic [1:0]  rom_sel;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [15:0] checksum;

  always #5 clk_sys = ~clk_sys;

  joust2_rom_loader #(
    .ROM_INDEX      (8'd0),
    .FIFO_DEPTH     (4),
    .WAIT_LEVEL     (2),
    .EXPECTED_BYTES (256)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_we         (rom_we),
    .rom_ack        (rom_ack),
    .rom_sel        (rom_sel),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_error     (load_error),
    .checksum       (checksum)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [1:0]  sel;
    logic [15:0] raddr;
  } vec_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  vec_t vecs [7];
  wr_t  exp_q [$];
  bit   mon_en = 1'b0;
  int   sel_cnt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: load_done=%b after %0d cycles, expected 1", name, load_done, n);
    end
  endtask

  // Scoreboard of accepted ROM writes during the full-load sequence.
  always @(negedge clk_sys) begin
    if (mon_en && rom_we && rom_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL full_write: unexpected write sel=%0d addr=%0h data=%0h", rom_sel, rom_addr, rom_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({rom_sel, rom_addr, rom_data} !== e) begin
          errors++;
          $display("FAIL full_write: got %0h, expected %0h", {rom_sel, rom_addr, rom_data}, e);
        end
        if (rom_sel < 2'd3) sel_cnt[rom_sel]++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          sum;
    logic [16:0] a;
    logic [7:0]  d;
    wr_t         w;

    vecs[0] = '{17'h00000, 8'h11, 2'd0, 16'h0000};
    vecs[1] = '{17'h0ABCD, 8'h22, 2'd0, 16'hABCD};
    vecs[2] = '{17'h0FFFF, 8'h33, 2'd0, 16'hFFFF};
    vecs[3] = '{17'h10000, 8'h44, 2'd1, 16'h0000};
    vecs[4] = '{17'h17FFF, 8'h55, 2'd1, 16'h7FFF};
    vecs[5] = '{17'h18004, 8'hA5, 2'd2, 16'h0004};
    vecs[6] = '{17'h1FFFF, 8'h5A, 2'd2, 16'h7FFF};
    sel_cnt[0] = 0; sel_cnt[1] = 0; sel_cnt[2] = 0;

    // Reset
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; rom_ack = 1'b0;
    tick(); tick(); tick();
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_sel", rom_sel, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_data", rom_data, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_checksum", checksum, 0);
    reset_n = 1'b1;
    tick();

    // Decode table, one byte at a time with 1-cycle latency check
    ioctl_download = 1'b1;
    tick();
    chk("start_busy", load_busy, 1);
    sum = 0;
    foreach (vecs[i]) begin
      ioctl_addr = vecs[i].addr; ioctl_dout = vecs[i].data; ioctl_wr = 1'b1;
      sum += vecs[i].data;
      tick();
      ioctl_wr = 1'b0;
      chk("vec_rom_we", rom_we, 1);
      chk("vec_rom_sel", rom_sel, vecs[i].sel);
      chk("vec_rom_addr", rom_addr, vecs[i].raddr);
      chk("vec_rom_data", rom_data, vecs[i].data);
      rom_ack = 1'b1;
      tick();
      rom_ack = 1'b0;
      chk("vec_popped", rom_we, 0);
    end
    ioctl_download = 1'b0;
    tick();
    chk("drain_busy", load_busy, 1);
    chk("drain_not_done", load_done, 0);
    tick();
    chk("vec_done", load_done, 1);
    chk("vec_busy_off", load_busy, 0);
    chk("vec_short_error", load_error, 1);
    chk("vec_checksum", checksum, sum & 16'hFFFF);

    // Back-pressure: ack held low, strobes every cycle
    ioctl_download = 1'b1;
    tick();
    chk("bp_restart_busy", load_busy, 1);
    chk("bp_error_cleared", load_error, 0);
    chk("bp_checksum_cleared", checksum, 0);
    for (int k = 0; k < 5; k++) begin
      ioctl_addr = 17'(k); ioctl_dout = 8'h31 + 8'(k); ioctl_wr = 1'b1;
      tick();
      if (k == 0) chk("bp_wait_after_1", ioctl_wait, 0);
      if (k == 1) chk("bp_wait_after_2", ioctl_wait, 1);
      if (k == 3) chk("bp_error_not_yet", load_error, 0);
      chk("bp_head_hold", rom_data, 8'h31);
    end
    ioctl_wr = 1'b0;
    chk("bp_overflow_error", load_error, 1);
    chk("bp_rom_we", rom_we, 1);
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_data", rom_data, 8'h31 + 8'(k));
      rom_ack = 1'b1;
      tick();
    end
    rom_ack = 1'b0;
    chk("bp_empty", rom_we, 0);
    chk("bp_wait_low", ioctl_wait, 0);
    chk("bp_checksum", checksum, 16'h00CA);
    ioctl_download = 1'b0;
    tick();
    wait_done("bp_done");
    chk("bp_error_sticky", load_error, 1);

    // Short load of 100 bytes
    ioctl_download = 1'b1;
    tick();
    rom_ack = 1'b1;
    sum = 0;
    for (int i = 0; i < 100; i++) begin
      d = 8'(i * 7 + 3);
      sum += d;
      ioctl_addr = 17'(i); ioctl_dout = d; ioctl_wr = 1'b1;
      tick();
    end
    chk("short_wait_low", ioctl_wait, 0);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    chk("short_drain_busy", load_busy, 1);
    chk("short_drain_not_done", load_done, 0);
    wait_done("short_done");
    chk("short_error", load_error, 1);
    chk("short_checksum", checksum, sum & 16'hFFFF);
    rom_ack = 1'b0;

    // Reset mid-load with 3 bytes buffered
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 17'(i); ioctl_dout = 8'hC0 + 8'(i); ioctl_wr = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    chk("rmid_rom_we_before", rom_we, 1);
    reset_n = 1'b0; ioctl_download = 1'b0;
    tick();
    chk("rmid_rom_we", rom_we, 0);
    chk("rmid_busy", load_busy, 0);
    chk("rmid_done", load_done, 0);
    chk("rmid_error", load_error, 0);
    reset_n = 1'b1;
    tick(); tick();
    chk("rmid_rom_we_after", rom_we, 0);

    // Foreign index: nothing may change
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 17'(i); ioctl_dout = 8'h77; ioctl_wr = 1'b1;
      tick();
      chk("idx1_rom_we", rom_we, 0);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick(); tick();
    chk("idx1_busy", load_busy, 0);
    chk("idx1_done", load_done, 0);
    chk("idx1_checksum", checksum, 0);
    chk("idx1_error", load_error, 0);
    chk("idx1_wait", ioctl_wait, 0);
    chk("idx1_rom_data", rom_data, 0);
    ioctl_index = 8'd0;

    // Full load: 128 CPU, 64 sound, 64 graphics bytes, data = addr[7:0]
    ioctl_download = 1'b1;
    tick();
    rom_ack = 1'b1;
    mon_en = 1'b1;
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < 128) begin
        a = 17'(i);
        w.sel = 2'd0; w.addr = 16'(i);
      end else if (i < 192) begin
        a = 17'h10000 + 17'(i - 128);
        w.sel = 2'd1; w.addr = 16'(i - 128);
      end else begin
        a = 17'h18000 + 17'(i - 192);
        w.sel = 2'd2; w.addr = 16'(i - 192);
      end
      d = a[7:0];
      w.data = d;
      exp_q.push_back(w);
      sum += d;
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    wait_done("full_done");
    tick();
    mon_en = 1'b0;
    chk("full_error", load_error, 0);
    chk("full_checksum", checksum, sum & 16'hFFFF);
    chk("full_sel0_count", sel_cnt[0], 128);
    chk("full_sel1_count", sel_cnt[1], 64);
    chk("full_sel2_count", sel_cnt[2], 64);
    chk("full_all_written", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
